// File: rtl/signed_serial_multiplier_12_ppa_brent_kung.sv
// rtl/signed_serial_multiplier_12_ppa_brent_kung.sv - sequential signed shift-add multiplier with Brent-Kung accumulate adder
// One partial product per clock; the sign bit of B is applied as a subtraction via adder carry-in.

module brent_kung_adder #(
    parameter int N = 24
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);
    localparam int LEVELS = $clog2(N);

    logic [N-1:0] p;
    logic [N-1:0] g;
    logic [N-1:0] gg;
    logic [N-1:0] pp;
    logic [N-1:0] carry;

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        pp = p;
        gg = g;
        // Folding cin into bit 0 makes every gg[i] the carry out of bit i.
        gg[0] = g[0] | (p[0] & cin);
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < N; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    int j;
                    j = (i >= (1 << l)) ? i - (1 << l) : 0;
                    gg[i] = gg[i] | (pp[i] & gg[j]);
                    pp[i] = pp[i] & pp[j];
                end
            end
        end
        for (int l = LEVELS - 2; l >= 0; l--) begin
            for (int i = 0; i < N; i++) begin
                if ((i >= (3 << l) - 1) && (((i + 1) % (2 << l)) == (1 << l))) begin
                    int j;
                    j = (i >= (1 << l)) ? i - (1 << l) : 0;
                    gg[i] = gg[i] | (pp[i] & gg[j]);
                end
            end
        end
        carry = {gg[N-2:0], cin};
        sum   = p ^ carry;
    end
endmodule

module signed_serial_multiplier_12_ppa_brent_kung #(
    parameter int width = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [width:1]     A,
    input  logic [width:1]     B,
    output logic               valid,
    output logic [2*width:1]   S
);
    localparam int PW = 2 * width;
    localparam int CW = $clog2(width);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic            start;
    logic            finish;
    logic [width-1:0] a_q;
    logic [width-1:0] b_q;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   a_ext;
    logic [PW-1:0]   shifted;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   sum;
    logic            cin;
    logic            last_step;

    assign a_ext     = {{width{a_q[width-1]}}, a_q};
    assign shifted   = a_ext << cnt;
    assign last_step = (cnt == CW'(width - 1));

    always_comb begin
        addend = '0;
        cin    = 1'b0;
        if (b_q[cnt]) begin
            // Top bit of B carries negative weight: add the two's complement.
            if (last_step) begin
                addend = ~shifted;
                cin    = 1'b1;
            end else begin
                addend = shifted;
            end
        end
    end

    brent_kung_adder #(.N(PW)) u_add (
        .a   (acc),
        .b   (addend),
        .cin (cin),
        .sum (sum)
    );

    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (en) begin
                    start      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            cnt   <= '0;
            valid <= 1'b0;
            S     <= '0;
        end else if (start) begin
            a_q   <= A;
            b_q   <= B;
            acc   <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (state == BUSY) begin
            acc <= sum;
            if (finish) begin
                S     <= sum;
                valid <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_signed_serial_multiplier_12_ppa_brent_kung.sv
// tb/tb_signed_serial_multiplier_12_ppa_brent_kung.sv - scoreboard bench for the serial signed multiplier

module tb_signed_serial_multiplier_12_ppa_brent_kung;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic [12:1] A;
    logic [12:1] B;
    logic        valid;
    logic [24:1] S;

    int checks = 0;
    int errors = 0;
    logic [23:0] sb[$];
    logic [23:0] prev_s;

    signed_serial_multiplier_12_ppa_brent_kung #(.width(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (A),
        .B     (B),
        .valid (valid),
        .S     (S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [23:0] model(input logic [11:0] a, input logic [11:0] b);
        int prod;
        prod = int'($signed(a)) * int'($signed(b));
        return prod[23:0];
    endfunction

    task automatic run_op(input logic [11:0] a, input logic [11:0] b, input logic [23:0] expected,
                          input bit inject);
        int lat;
        logic [23:0] exp_s;
        sb.push_back(expected);
        @(posedge clk); #1;
        A = a; B = b; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        A = 12'($urandom);
        B = 12'($urandom);
        check("start_clears_valid", {31'd0, valid}, 32'd0);
        lat = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 6 && inject) en = 1'b0;
            if (valid) begin
                lat = cyc;
                break;
            end
            if (cyc == 6) check("s_held_busy", {8'd0, S}, {8'd0, prev_s});
            if (cyc == 5 && inject) begin
                A = 12'd1; B = 12'd1; en = 1'b1;
            end
        end
        if (lat == 0) lat = 21;
        check("latency", lat, 32'd12);
        exp_s = sb.pop_front();
        check("product", {8'd0, S}, {8'd0, exp_s});
        prev_s = exp_s;
    endtask

    initial begin
        logic [11:0] ra;
        logic [11:0] rb;
        rst_n = 1'b0; en = 1'b0; A = '0; B = '0;
        prev_s = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_s", {8'd0, S}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_valid", {31'd0, valid}, 32'd0);
        check("idle_s", {8'd0, S}, 32'd0);

        run_op(12'd3, 12'd5, 24'h00000F, 1'b0);
        run_op(12'hFFF, 12'hFFF, 24'h000001, 1'b0);
        run_op(12'h800, 12'h800, 24'h400000, 1'b0);
        run_op(12'h7FF, 12'h800, 24'hC00800, 1'b0);
        run_op(12'h123, 12'h045, 24'h004E6F, 1'b1);
        run_op(12'hFFE, 12'h003, 24'hFFFFFA, 1'b0);

        // abort after step 6 of an operation with a nonzero result on S
        @(posedge clk); #1;
        A = 12'h321; B = 12'h0AB; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_s", {8'd0, S}, 32'd0);
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        rst_n = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("no_start_in_reset", {31'd0, valid}, 32'd0);
        prev_s = '0;

        for (int k = 0; k < 50; k++) begin
            ra = 12'($urandom);
            rb = 12'($urandom);
            run_op(ra, rb, model(ra, rb), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
